// File: rtl/uart_baudgen_frac.sv
// uart_baudgen_frac: fractional, runtime-programmable baud tick generator.
// Emits single-cycle oversample, bit and mid-bit strobes plus the oversample
// index. Optional feature macro: UART_BAUDGEN_FRAC_EN enables the fractional
// accumulator; when undefined the period is exactly the clamped integer divisor.
module uart_baudgen_frac #(
    parameter int IntWidth      = 16,
    parameter int FracWidth     = 4,
    parameter int OverSample    = 8,
    parameter int DefaultDivInt = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_en,
    input  logic [IntWidth-1:0]           i_div_int,
    input  logic [FracWidth-1:0]          i_div_frac,
    input  logic                          i_div_load,
    input  logic                          i_resync,
    output logic                          o_os_tick,
    output logic                          o_bit_tick,
    output logic                          o_mid_tick,
    output logic [$clog2(OverSample)-1:0] o_os_idx,
    output logic                          o_div_err
);

    localparam int IdxW = $clog2(OverSample);
    localparam int CntW = IntWidth + 1;

    // Divisors below 2 cannot produce distinct strobes; saturate them to 2.
    function automatic logic [IntWidth-1:0] clamp_div(input logic [IntWidth-1:0] d);
        return (d < IntWidth'(2)) ? IntWidth'(2) : d;
    endfunction

    // The active divisor is only consumed at the instant it is captured
    // (reload or resync), so it is folded directly into cnt/acc instead of
    // being held in a separate register.
    logic [IntWidth-1:0] shadow_int;
    logic [IntWidth-1:0] nxt_int;
    logic [IntWidth-1:0] eff_int;
    logic [CntW-1:0]     cnt;
    logic [CntW-1:0]     reload_cnt;
    logic [CntW-1:0]     resync_cnt;
    logic                carry;
    logic [IdxW-1:0]     idx_next;

`ifdef UART_BAUDGEN_FRAC_EN
    logic [FracWidth-1:0] shadow_frac;
    logic [FracWidth-1:0] nxt_frac;
    logic [FracWidth-1:0] acc;
    logic [FracWidth:0]   acc_sum;
`else
    logic unused_frac;
    assign unused_frac = ^i_div_frac;
`endif

    // Next active divisor (load bypasses the shadow) and the reload arithmetic.
    always_comb begin
        nxt_int    = i_div_load ? i_div_int : shadow_int;
        eff_int    = clamp_div(nxt_int);
`ifdef UART_BAUDGEN_FRAC_EN
        nxt_frac   = i_div_load ? i_div_frac : shadow_frac;
        acc_sum    = {1'b0, acc} + {1'b0, nxt_frac};
        carry      = acc_sum[FracWidth];
`else
        carry      = 1'b0;
`endif
        reload_cnt = CntW'(eff_int) + CntW'(carry) - CntW'(1);
        resync_cnt = CntW'(eff_int) - CntW'(1);
        idx_next   = (o_os_idx == IdxW'(OverSample - 1)) ? '0 : o_os_idx + IdxW'(1);
    end

    // Shadow divisor write and divisor-error flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shadow_int  <= IntWidth'(DefaultDivInt);
`ifdef UART_BAUDGEN_FRAC_EN
            shadow_frac <= '0;
`endif
            o_div_err   <= 1'b0;
        end else if (i_div_load) begin
            shadow_int  <= i_div_int;
`ifdef UART_BAUDGEN_FRAC_EN
            shadow_frac <= i_div_frac;
`endif
            o_div_err   <= (i_div_int < IntWidth'(2));
        end
    end

    // Period counter, fractional phase, oversample index and tick strobes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt        <= CntW'(DefaultDivInt - 1);
`ifdef UART_BAUDGEN_FRAC_EN
            acc        <= '0;
`endif
            o_os_idx   <= '0;
            o_os_tick  <= 1'b0;
            o_bit_tick <= 1'b0;
            o_mid_tick <= 1'b0;
        end else begin
            o_os_tick  <= 1'b0;
            o_bit_tick <= 1'b0;
            o_mid_tick <= 1'b0;
            if (i_resync) begin
                cnt      <= resync_cnt;
`ifdef UART_BAUDGEN_FRAC_EN
                acc      <= '0;
`endif
                o_os_idx <= '0;
            end else if (i_en) begin
                if (cnt != '0) begin
                    cnt <= cnt - CntW'(1);
                end else begin
                    cnt        <= reload_cnt;
`ifdef UART_BAUDGEN_FRAC_EN
                    acc        <= acc_sum[FracWidth-1:0];
`endif
                    o_os_idx   <= idx_next;
                    o_os_tick  <= 1'b1;
                    o_bit_tick <= (idx_next == '0);
                    o_mid_tick <= (idx_next == IdxW'(OverSample / 2));
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_baudgen_frac.sv
// Self-checking bench for uart_baudgen_frac: directed scenarios followed by a
// randomized phase, every cycle compared against a behavioural model.
module tb_uart_baudgen_frac;

    localparam int IW  = 16;
    localparam int FW  = 4;
    localparam int OS  = 8;
    localparam int DD  = 4;
    localparam int IXW = $clog2(OS);
`ifdef UART_BAUDGEN_FRAC_EN
    localparam bit HasFrac = 1'b1;
`else
    localparam bit HasFrac = 1'b0;
`endif

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic           i_en;
    logic [IW-1:0]  i_div_int;
    logic [FW-1:0]  i_div_frac;
    logic           i_div_load;
    logic           i_resync;
    logic           o_os_tick;
    logic           o_bit_tick;
    logic           o_mid_tick;
    logic [IXW-1:0] o_os_idx;
    logic           o_div_err;

    int total = 0;
    int bad   = 0;

    // Model state: edges left until the next tick, fractional phase sum,
    // tick position within the bit, shadow divisor, expected strobes.
    int m_sh_int, m_sh_frac, m_left, m_fsum, m_idx;
    bit e_os, e_bit, e_mid, e_err;

    uart_baudgen_frac #(
        .IntWidth(IW), .FracWidth(FW), .OverSample(OS), .DefaultDivInt(DD)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en),
        .i_div_int(i_div_int), .i_div_frac(i_div_frac),
        .i_div_load(i_div_load), .i_resync(i_resync),
        .o_os_tick(o_os_tick), .o_bit_tick(o_bit_tick), .o_mid_tick(o_mid_tick),
        .o_os_idx(o_os_idx), .o_div_err(o_div_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs about to be sampled.
    task automatic model_step();
        int nint, nfrac, s, eff;
        if (i_rst) begin
            m_sh_int = DD; m_sh_frac = 0; m_left = DD; m_fsum = 0; m_idx = 0;
            e_os = 0; e_bit = 0; e_mid = 0; e_err = 0;
            return;
        end
        nint  = i_div_load ? int'(i_div_int) : m_sh_int;
        nfrac = HasFrac ? (i_div_load ? int'(i_div_frac) : m_sh_frac) : 0;
        eff   = (nint < 2) ? 2 : nint;
        e_os = 0; e_bit = 0; e_mid = 0;
        if (i_resync) begin
            m_left = eff; m_fsum = 0; m_idx = 0;
        end else if (i_en) begin
            m_left--;
            if (m_left == 0) begin
                s      = m_fsum + nfrac;
                m_left = eff + s / (1 << FW);
                m_fsum = s % (1 << FW);
                m_idx  = (m_idx + 1) % OS;
                e_os   = 1;
                e_bit  = (m_idx == 0);
                e_mid  = (m_idx == OS / 2);
            end
        end
        if (i_div_load) begin
            m_sh_int = int'(i_div_int); m_sh_frac = int'(i_div_frac);
            e_err    = (i_div_int < 2);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge i_clk);
        #1;
        chk("os_tick",  32'(o_os_tick),  32'(e_os));
        chk("bit_tick", 32'(o_bit_tick), 32'(e_bit));
        chk("mid_tick", 32'(o_mid_tick), 32'(e_mid));
        chk("os_idx",   32'(o_os_idx),   32'(m_idx));
        chk("div_err",  32'(o_div_err),  32'(e_err));
        i_div_load = 1'b0;
        i_resync   = 1'b0;
    endtask

    // Run until o_os_tick is seen; n = edges taken, or -1 if the budget expires.
    task automatic wait_tick(input int maxc, output int n);
        n = -1;
        for (int k = 1; k <= maxc; k++) begin
            cycle();
            if (o_os_tick === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic load_div(input int di, input int df, input bit rs);
        i_div_int  = IW'(di);
        i_div_frac = FW'(df);
        i_div_load = 1'b1;
        i_resync   = rs;
        cycle();
    endtask

    initial begin
        int n, cnt_t;
        bit found;
        int exp_gap[5];

        i_rst = 1'b1; i_en = 1'b0; i_div_load = 1'b0; i_resync = 1'b0;
        i_div_int = '0; i_div_frac = '0;
        repeat (3) cycle();
        chk("rst_os_tick", 32'(o_os_tick), 0);
        chk("rst_idx",     32'(o_os_idx),  0);
        chk("rst_err",     32'(o_div_err), 0);

        // Reset defaults: ticks every 4 edges, mid at 16, bit wrap at 32.
        i_rst = 1'b0; i_en = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            cycle();
            if (e == 3) chk("t1_no_early_tick", 32'(o_os_tick), 0);
            if (e == 4) chk("t1_first_tick", 32'(o_os_tick), 1);
            if (e == 16) chk("t1_mid_tick", 32'(o_mid_tick), 1);
            if (e == 32) begin
                chk("t1_bit_tick", 32'(o_bit_tick), 1);
                chk("t1_idx_wrap", 32'(o_os_idx), 0);
            end
        end

        // Fractional period 4.5.
        load_div(4, 8, 1'b0);
        i_resync = 1'b1; cycle();
        cnt_t = 0;
        for (int e = 1; e <= 72; e++) begin
            cycle();
            if (o_os_tick === 1'b1) cnt_t++;
        end
        chk("t2_ticks_in_72", cnt_t, HasFrac ? 16 : 18);
        i_resync = 1'b1; cycle();
        if (HasFrac) exp_gap = '{4, 4, 5, 4, 5};
        else         exp_gap = '{4, 4, 4, 4, 4};
        for (int g = 0; g < 5; g++) begin
            wait_tick(20, n);
            chk("t2_gap", n, exp_gap[g]);
        end

        // Mid-period load keeps the running period; load+resync bypasses.
        load_div(4, 0, 1'b1);
        cycle(); cycle();
        i_div_int = IW'(10); i_div_load = 1'b1;
        wait_tick(20, n);
        chk("t3_cur_period", n, 2);
        wait_tick(20, n);
        chk("t3_next_period", n, 10);
        load_div(4, 0, 1'b0);
        load_div(10, 0, 1'b1);
        wait_tick(20, n);
        chk("t3_load_resync", n, 10);

        // Resync in the middle of a bit.
        load_div(4, 8, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            cycle();
            if (o_os_idx === IXW'(5)) found = 1'b1;
        end
        chk("t4_reach_idx5", 32'(found), 1);
        cycle();
        i_resync = 1'b1; cycle();
        chk("t4_idx_zero", 32'(o_os_idx), 0);
        wait_tick(20, n); chk("t4_p1", n, 4);
        wait_tick(20, n); chk("t4_p2", n, 4);
        wait_tick(20, n); chk("t4_p3", n, HasFrac ? 5 : 4);

        // Enable gap and clamping.
        load_div(4, 0, 1'b1);
        cycle(); cycle();
        i_en = 1'b0;
        cnt_t = 0;
        repeat (7) begin
            cycle();
            if (o_os_tick !== 1'b0) cnt_t++;
        end
        chk("t5_no_tick_disabled", cnt_t, 0);
        i_en = 1'b1;
        wait_tick(20, n); chk("t5_delayed_tick", n, 2);
        load_div(1, 0, 1'b0);
        chk("t5_err_int1", 32'(o_div_err), 1);
        i_resync = 1'b1; cycle();
        wait_tick(20, n); chk("t5_clamp1_a", n, 2);
        wait_tick(20, n); chk("t5_clamp1_b", n, 2);
        load_div(0, 0, 1'b1);
        chk("t5_err_int0", 32'(o_div_err), 1);
        wait_tick(20, n); chk("t5_clamp0", n, 2);
        load_div(5, 0, 1'b0);
        chk("t5_err_clear", 32'(o_div_err), 0);

        // Reset mid-operation restores default timing.
        load_div(9, 0, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            cycle();
            if (o_os_idx === IXW'(6)) found = 1'b1;
        end
        chk("t6_reach_idx6", 32'(found), 1);
        i_rst = 1'b1; cycle();
        chk("t6_rst_idx",  32'(o_os_idx),  0);
        chk("t6_rst_tick", 32'(o_os_tick), 0);
        i_rst = 1'b0;
        wait_tick(20, n); chk("t6_first_tick", n, 4);
        wait_tick(20, n); chk("t6_second_tick", n, 4);

        // Randomized traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            i_en       = ($urandom_range(0, 9) != 0);
            i_div_load = ($urandom_range(0, 24) == 0);
            i_div_int  = IW'($urandom_range(0, 12));
            i_div_frac = FW'($urandom);
            i_resync   = ($urandom_range(0, 59) == 0);
            i_rst      = ($urandom_range(0, 399) == 0);
            cycle();
        end
        i_rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
